// File: rtl/xmem_loader.sv
// Streams words into an xmem port at base + k*stride; write appears 1 cycle after acceptance.
// Backpressure: s_ready drops outside LOAD and whenever hold is high.
module xmem_loader #(
  parameter int MEM_ADDR_W = 10,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  hold,
  input  logic [MEM_ADDR_W-1:0] base_addr,
  input  logic [MEM_ADDR_W-1:0] stride,
  input  logic [MEM_ADDR_W:0]   length,
  output logic                  busy,
  output logic                  done,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_W-1:0]     s_data,
  output logic                  mem_valid,
  output logic                  mem_we,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0]     mem_wdata
);

  typedef enum logic [1:0] {IDLE, LOAD, FIN} state_t;

  localparam logic [MEM_ADDR_W:0] CNT_ONE = 1;

  state_t                state, state_nxt;
  logic [MEM_ADDR_W-1:0] stride_r;
  logic [MEM_ADDR_W-1:0] addr_acc;
  logic [MEM_ADDR_W:0]   len_r;
  logic [MEM_ADDR_W:0]   cnt;
  logic [MEM_ADDR_W:0]   cnt_inc;
  logic                  accept;
  logic                  cfg_load;

  assign cnt_inc  = cnt + CNT_ONE;
  assign busy     = (state != IDLE);
  assign cfg_load = (state == IDLE) && start;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    s_ready   = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = (length == '0) ? FIN : LOAD;
      end
      LOAD: begin
        s_ready = ~hold;
        accept  = s_valid & ~hold;
        if (accept && (cnt_inc == len_r)) state_nxt = FIN;
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // addr_acc always holds the address of the next word to be accepted
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stride_r  <= '0;
      len_r     <= '0;
      addr_acc  <= '0;
      cnt       <= '0;
      mem_valid <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      done      <= 1'b0;
    end else begin
      mem_valid <= accept;
      mem_we    <= accept;
      done      <= (state_nxt == FIN);
      if (cfg_load) begin
        stride_r <= stride;
        len_r    <= length;
        addr_acc <= base_addr;
        cnt      <= '0;
      end else if (accept) begin
        mem_addr  <= addr_acc;
        mem_wdata <= s_data;
        addr_acc  <= addr_acc + stride_r;
        cnt       <= cnt_inc;
      end
    end
  end

endmodule

// File: tb/tb_xmem_loader.sv
// Randomized bench for xmem_loader; expected writes come from base + k*stride mod 2^10.
module tb_xmem_loader;

  localparam int AW = 10;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          start, hold, s_valid;
  logic [AW-1:0] base_addr, stride;
  logic [AW:0]   length;
  logic [DW-1:0] s_data;
  logic          busy, done, s_ready, mem_valid, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;

  xmem_loader #(.MEM_ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .hold(hold),
    .base_addr(base_addr), .stride(stride), .length(length),
    .busy(busy), .done(done), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t exp_q[$];
  int  n_cmp = 0;
  int  n_err = 0;
  int  cyc = 0;
  int  wr_cnt = 0;
  int  first_wr_cyc = -1;
  int  done_cnt = 0;
  logic prev_acc = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(posedge clk) cyc++;

  // Scoreboard: every write must match the next expected word, and follow an acceptance
  always @(negedge clk) begin
    if (!rst) begin
      prev_acc = 1'b0;
    end else begin
      if (mem_valid) begin
        chk("mem_we", mem_we, 1);
        if (exp_q.size() == 0) begin
          chk("extra_write", 1, 0);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("mem_addr", mem_addr, e.a);
          chk("mem_wdata", mem_wdata, e.d);
        end
        if (wr_cnt == 0) first_wr_cyc = cyc;
        wr_cnt++;
      end else begin
        chk("we_idle", mem_we, 0);
      end
      if (done) done_cnt++;
      chk("wr_needs_accept", mem_valid, prev_acc);
      chk("rdy_under_hold", s_ready & hold, 0);
      chk("rdy_when_idle", s_ready & ~busy, 0);
      prev_acc = s_valid & s_ready;
    end
  end

  task automatic run_xfer(input int base, input int strd, input int len, input int p_valid,
                          input int hold_at, input int hold_n, input bit rnd_hold,
                          input bit spur, input int rst_after, input bit seq_dat,
                          input bit lat_chk);
    logic [DW-1:0] dat[$];
    int k, budget, hold_left, start_cyc;
    bit hold_done, spur_done;
    dat.delete();
    for (int i = 0; i < len; i++) begin
      wr_t e;
      dat.push_back(seq_dat ? DW'(32'hA0 + i) : DW'($urandom));
      e.a = AW'((base + i * strd) % (1 << AW));
      e.d = dat[i];
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    chk("idle_before_start", busy, 0);
    wr_cnt = 0; first_wr_cyc = -1; done_cnt = 0;
    base_addr = AW'(base); stride = AW'(strd); length = (AW+1)'(len);
    start = 1'b1; start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    base_addr = AW'($urandom); stride = AW'($urandom); length = (AW+1)'($urandom_range(0, 9));
    chk("busy_rise", busy, 1);
    if (len == 0) begin
      chk("done_len0", done, 1);
      chk("no_write_len0", mem_valid, 0);
      @(posedge clk); #1;
      chk("busy_fall_len0", busy, 0);
      chk("done_pulse_len0", done, 0);
      return;
    end
    k = 0; budget = 30 * len + 50; hold_left = 0; hold_done = 0; spur_done = 0;
    while (k < len && budget > 0) begin
      start = 1'b0;
      if (spur && !spur_done && k == 2) begin
        start = 1'b1; spur_done = 1;
      end
      if (hold_left > 0) begin
        hold = 1'b1; hold_left--;
      end else if (hold_at >= 0 && k == hold_at && !hold_done) begin
        hold = 1'b1; hold_left = hold_n - 1; hold_done = 1;
      end else begin
        hold = rnd_hold ? ($urandom_range(0, 3) == 0) : 1'b0;
      end
      s_valid = ($urandom_range(0, 99) < p_valid);
      s_data  = s_valid ? dat[k] : DW'($urandom);
      @(negedge clk); #1;
      if (s_valid && s_ready) k++;
      if (rst_after > 0 && wr_cnt == rst_after) begin
        rst = 1'b0; s_valid = 1'b0; hold = 1'b0; start = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_s_ready", s_ready, 0);
        chk("abort_mem_valid", mem_valid, 0);
        chk("abort_mem_we", mem_we, 0);
        chk("abort_mem_addr", mem_addr, 0);
        chk("abort_mem_wdata", mem_wdata, 0);
        exp_q.delete();
        return;
      end
      budget--;
      @(posedge clk); #1;
    end
    start = 1'b0; s_valid = 1'b0; hold = 1'b0;
    if (budget == 0) begin
      chk("accept_timeout", k, len);
      exp_q.delete();
      return;
    end
    chk("done_with_last", done, 1);
    chk("last_write", mem_valid, 1);
    @(negedge clk); #1;
    chk("all_written", exp_q.size(), 0);
    @(posedge clk); #1;
    chk("done_pulse", done, 0);
    chk("busy_fall", busy, 0);
    chk("done_count", done_cnt, 1);
    chk("write_count", wr_cnt, len);
    if (lat_chk) chk("first_write_latency", first_wr_cyc - start_cyc, 2);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; hold = 1'b0; s_valid = 1'b0;
    base_addr = '0; stride = '0; length = '0; s_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_mem_valid", mem_valid, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    rst = 1'b1;

    run_xfer(5, 1, 4, 100, -1, 0, 0, 0, 0, 1, 1);
    run_xfer(1020, 3, 3, 100, -1, 0, 0, 0, 0, 0, 1);
    run_xfer(77, 9, 0, 100, -1, 0, 0, 0, 0, 0, 0);
    run_xfer(100, 7, 4, 60, 1, 5, 0, 0, 0, 0, 0);
    run_xfer(200, 2, 5, 100, -1, 0, 0, 1, 0, 0, 0);
    run_xfer(300, 1, 6, 100, -1, 0, 0, 0, 2, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    run_xfer(40, 5, 2, 100, -1, 0, 0, 0, 0, 0, 1);
    run_xfer(7, 1, 1024, 90, -1, 0, 1, 0, 0, 0, 0);
    for (int t = 0; t < 25; t++) begin
      run_xfer($urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 12),
               $urandom_range(30, 100), -1, 0, 1, ($urandom_range(0, 3) == 0), 0, 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
